// File: rtl/interrupt_timer_source.sv
// rtl/interrupt_timer_source.sv - programmable down-counter and software interrupt source on the IO bus
module interrupt_timer_source #(
  parameter logic [31:0] BASE_ADDRESS      = 32'h0011_0000,
  parameter int          NUM_TIMERS        = 2,
  parameter int          NUM_SW_INTERRUPTS = 2,
  parameter int          NUM_INTERRUPTS    = 16,
  parameter int          PULSE_CYCLES      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_write_en,
  input  logic                      io_read_en,
  input  logic [31:0]               io_address,
  input  logic [31:0]               io_write_data,
  output logic [31:0]               io_read_data,
  output logic [NUM_INTERRUPTS-1:0] interrupt_req
);
  localparam int            PW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

  logic [31:0] offset;
  logic        in_window;
  logic        timer_space;
  logic        sw_space;
  logic [3:0]  timer_idx;
  logic [1:0]  reg_idx;

  assign offset      = io_address - BASE_ADDRESS;
  assign in_window   = (offset[1:0] == 2'b00) && (offset <= 32'h0000_010B);
  assign timer_space = in_window && (offset < 32'h0000_0100);
  assign sw_space    = in_window && (offset >= 32'h0000_0100);
  assign timer_idx   = offset[7:4];
  assign reg_idx     = offset[3:2];

  logic [31:0]                  load_q      [NUM_TIMERS];
  logic [31:0]                  load_d      [NUM_TIMERS];
  logic [31:0]                  count_q     [NUM_TIMERS];
  logic [31:0]                  count_d     [NUM_TIMERS];
  logic [PW-1:0]                pulse_cnt_q [NUM_TIMERS];
  logic [PW-1:0]                pulse_cnt_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]        enable_q, enable_d;
  logic [NUM_TIMERS-1:0]        periodic_q, periodic_d;
  logic [NUM_TIMERS-1:0]        pulse_mode_q, pulse_mode_d;
  logic [NUM_TIMERS-1:0]        status_q, status_d;
  logic [NUM_TIMERS-1:0]        sel;
  logic [NUM_SW_INTERRUPTS-1:0] sw_q, sw_d;
  logic [NUM_INTERRUPTS-1:0]    irq_d;
  logic [31:0]                  rd_d;

  always_comb begin
    sel = '0;
    for (int t = 0; t < NUM_TIMERS; t++) begin
      sel[t] = timer_space && (timer_idx == 4'(t));
    end
  end

  always_comb begin
    load_d       = load_q;
    count_d      = count_q;
    pulse_cnt_d  = pulse_cnt_q;
    enable_d     = enable_q;
    periodic_d   = periodic_q;
    pulse_mode_d = pulse_mode_q;
    status_d     = status_q;
    sw_d         = sw_q;
    irq_d        = '0;
    rd_d         = io_read_en ? 32'd0 : io_read_data;

    for (int t = 0; t < NUM_TIMERS; t++) begin
      if (io_read_en && sel[t]) begin
        case (reg_idx)
          2'd0:    rd_d = load_q[t];
          2'd1:    rd_d = count_q[t];
          2'd2:    rd_d = {29'd0, pulse_mode_q[t], periodic_q[t], enable_q[t]};
          default: rd_d = {31'd0, status_q[t]};
        endcase
      end
      if (io_write_en && sel[t] && reg_idx == 2'd0) load_d[t] = io_write_data;

      // A CTRL write restarts the timer outright and overrides an expiry landing on the same edge.
      if (io_write_en && sel[t] && reg_idx == 2'd2) begin
        enable_d[t]     = io_write_data[0];
        periodic_d[t]   = io_write_data[1];
        pulse_mode_d[t] = io_write_data[2];
        status_d[t]     = 1'b0;
        pulse_cnt_d[t]  = '0;
        if (io_write_data[0]) count_d[t] = load_q[t];
      end else begin
        if (pulse_cnt_q[t] != '0) pulse_cnt_d[t] = pulse_cnt_q[t] - 1'b1;
        if (io_write_en && sel[t] && reg_idx == 2'd3) status_d[t] = 1'b0;
        if (enable_q[t] && count_q[t] == 32'd1) begin
          if (periodic_q[t]) begin
            count_d[t] = load_q[t];
          end else begin
            count_d[t]  = 32'd0;
            enable_d[t] = 1'b0;
          end
          if (pulse_mode_q[t]) pulse_cnt_d[t] = PULSE_LOAD;
          else                 status_d[t]    = 1'b1;
        end else if (enable_q[t] && count_q[t] > 32'd1) begin
          count_d[t] = count_q[t] - 32'd1;
        end
      end
      irq_d[t] = pulse_mode_d[t] ? (pulse_cnt_d[t] != '0) : status_d[t];
    end

    if (io_write_en && sw_space && reg_idx == 2'd0) sw_d = sw_q | io_write_data[NUM_SW_INTERRUPTS-1:0];
    if (io_write_en && sw_space && reg_idx == 2'd1) sw_d = sw_q & ~io_write_data[NUM_SW_INTERRUPTS-1:0];
    if (io_read_en && sw_space && reg_idx == 2'd2) rd_d[NUM_SW_INTERRUPTS-1:0] = sw_q;
    for (int i = 0; i < NUM_SW_INTERRUPTS; i++) begin
      irq_d[NUM_TIMERS+i] = sw_d[i];
    end
  end

  // Outputs are registered from next-state so lines move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_TIMERS; t++) begin
        load_q[t]      <= 32'd0;
        count_q[t]     <= 32'd0;
        pulse_cnt_q[t] <= '0;
      end
      enable_q      <= '0;
      periodic_q    <= '0;
      pulse_mode_q  <= '0;
      status_q      <= '0;
      sw_q          <= '0;
      interrupt_req <= '0;
      io_read_data  <= 32'd0;
    end else begin
      load_q        <= load_d;
      count_q       <= count_d;
      pulse_cnt_q   <= pulse_cnt_d;
      enable_q      <= enable_d;
      periodic_q    <= periodic_d;
      pulse_mode_q  <= pulse_mode_d;
      status_q      <= status_d;
      sw_q          <= sw_d;
      interrupt_req <= irq_d;
      io_read_data  <= rd_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(io_read_en && io_write_en));
endmodule

// File: tb/tb_interrupt_timer_source.sv
// tb/tb_interrupt_timer_source.sv - self-checking bench with an event-time reference model
module tb_interrupt_timer_source;
  localparam logic [31:0] BASE = 32'h0011_0000;
  localparam int NT = 2;
  localparam int NS = 2;
  localparam int NI = 16;
  localparam int PC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_write_en;
  logic          io_read_en;
  logic [31:0]   io_address;
  logic [31:0]   io_write_data;
  logic [31:0]   io_read_data;
  logic [NI-1:0] interrupt_req;

  interrupt_timer_source #(
    .BASE_ADDRESS(BASE), .NUM_TIMERS(NT), .NUM_SW_INTERRUPTS(NS),
    .NUM_INTERRUPTS(NI), .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(reset), .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .interrupt_req(interrupt_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model: each timer is described by the absolute edge of its next event, not by a counter.
  longint      cyc = 0;
  bit          m_en [NT];
  bit          m_per [NT];
  bit          m_pm [NT];
  bit          m_status [NT];
  logic [31:0] m_load [NT];
  logic [31:0] m_held [NT];
  longint      m_next [NT];
  longint      m_pulse_until [NT];
  logic [NS-1:0] m_sw;
  logic [31:0] m_rd;

  function automatic logic [31:0] m_count(int t, longint m);
    if (m_en[t] && m_next[t] >= 0) return 32'(m_next[t] - m);
    return m_held[t];
  endfunction

  function automatic logic [NI-1:0] m_irq(longint m);
    logic [NI-1:0] v = '0;
    for (int k = 0; k < NT; k++) v[k] = m_pm[k] ? (m < m_pulse_until[k]) : m_status[k];
    for (int i = 0; i < NS; i++) v[NT+i] = m_sw[i];
    return v;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a, longint m);
    logic [31:0] off = a - BASE;
    int t;
    if (off[1:0] != 2'b00 || off > 32'h10B) return 32'd0;
    if (off < 32'h100) begin
      t = int'(off[7:4]);
      if (t >= NT) return 32'd0;
      case (off[3:2])
        2'd0:    return m_load[t];
        2'd1:    return m_count(t, m);
        2'd2:    return {29'd0, m_pm[t], m_per[t], m_en[t]};
        default: return {31'd0, m_status[t]};
      endcase
    end
    if (off[3:2] == 2'd2) return 32'(m_sw);
    return 32'd0;
  endfunction

  task automatic model_update();
    longint n = cyc;
    logic [31:0] off;
    logic [31:0] d;
    int t = -1;
    int r = -1;
    bit sw_w = 1'b0;
    if (reset) begin
      for (int k = 0; k < NT; k++) begin
        m_en[k] = 0; m_per[k] = 0; m_pm[k] = 0; m_status[k] = 0;
        m_load[k] = 0; m_held[k] = 0; m_next[k] = -1; m_pulse_until[k] = 0;
      end
      m_sw = '0;
      m_rd = 32'd0;
      return;
    end
    if (io_read_en) m_rd = m_read(io_address, n - 1);
    off = io_address - BASE;
    d = io_write_data;
    if (io_write_en && off[1:0] == 2'b00 && off <= 32'h10B) begin
      r = int'(off[3:2]);
      if (off < 32'h100) begin
        if (int'(off[7:4]) < NT) t = int'(off[7:4]);
      end else sw_w = 1'b1;
    end
    if (t >= 0 && r == 3) m_status[t] = 0;
    for (int k = 0; k < NT; k++) begin
      if (!(t == k && r == 2) && m_en[k] && m_next[k] == n) begin
        if (m_per[k]) begin
          if (m_load[k] == 0) begin m_next[k] = -1; m_held[k] = 0; end
          else m_next[k] = n + m_load[k];
        end else begin
          m_en[k] = 0; m_held[k] = 0;
        end
        if (m_pm[k]) m_pulse_until[k] = n + PC;
        else m_status[k] = 1;
      end
    end
    if (t >= 0 && r == 0) m_load[t] = d;
    if (t >= 0 && r == 2) begin
      m_held[t] = m_count(t, n - 1);
      m_en[t] = d[0]; m_per[t] = d[1]; m_pm[t] = d[2];
      m_status[t] = 0; m_pulse_until[t] = 0;
      if (d[0]) begin
        if (m_load[t] == 0) begin m_next[t] = -1; m_held[t] = 0; end
        else m_next[t] = n + m_load[t];
      end
    end
    if (sw_w && r == 0) m_sw = m_sw | d[NS-1:0];
    if (sw_w && r == 1) m_sw = m_sw & ~d[NS-1:0];
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (interrupt_req !== m_irq(cyc)) begin
        errors++;
        $display("FAIL irq cyc=%0d: got %h expected %h", cyc, interrupt_req, m_irq(cyc));
      end
      checks++;
      if (io_read_data !== m_rd) begin
        errors++;
        $display("FAIL read_data cyc=%0d: got %h expected %h", cyc, io_read_data, m_rd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc_op(input bit rst, input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    reset = rst; io_write_en = we; io_read_en = re; io_address = a; io_write_data = d;
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cyc_op(1'b0, 1'b1, 1'b0, BASE + off, d);
  endtask
  task automatic rd(input logic [31:0] off);
    cyc_op(1'b0, 1'b0, 1'b1, BASE + off, $urandom);
  endtask
  task automatic idle();
    cyc_op(1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask
  task automatic do_reset();
    cyc_op(1'b1, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    int lat, highs, gap1, gap2, r;
    bit prev;
    logic [31:0] off;
    do_reset();
    chk_on = 1'b1;
    do_reset();
    chk("reset_irq", 32'(interrupt_req), 32'd0);
    chk("reset_rd", io_read_data, 32'd0);

    // One-shot level timer.
    wr(32'h0, 32'd5);
    wr(32'h8, 32'd1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (interrupt_req[0]) begin lat = i; break; end
    end
    chk("oneshot_latency", 32'(lat), 32'd5);
    rd(32'h4); chk("oneshot_count", io_read_data, 32'd0);
    rd(32'h8); chk("oneshot_ctrl", io_read_data, 32'd0);
    rd(32'hC); chk("oneshot_status", io_read_data, 32'd1);
    wr(32'hC, 32'd0); chk("ack_clears", 32'(interrupt_req[0]), 32'd0);

    // Periodic pulse timer, then LOAD change mid-period.
    wr(32'h10, 32'd10);
    wr(32'h18, 32'd7);
    highs = 0;
    for (int i = 1; i <= 33; i++) begin
      idle();
      if (interrupt_req[1]) highs++;
    end
    chk("pulse_high_cycles", 32'(highs), 32'd12);
    wr(32'h10, 32'd20);
    prev = interrupt_req[1];
    gap1 = -1;
    for (int i = 1; i <= 30; i++) begin
      idle();
      if (interrupt_req[1] && !prev) begin gap1 = i; break; end
      prev = interrupt_req[1];
    end
    chk("reload_gap_old", 32'(gap1), 32'd6);
    prev = interrupt_req[1];
    gap2 = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (interrupt_req[1] && !prev) begin gap2 = i; break; end
      prev = interrupt_req[1];
    end
    chk("reload_gap_new", 32'(gap2), 32'd20);
    wr(32'h18, 32'd0);

    // ACK landing on the expiry edge loses to the event.
    wr(32'h0, 32'd3);
    wr(32'h8, 32'd1);
    idle(); idle();
    wr(32'hC, 32'd0);
    chk("ack_vs_event", 32'(interrupt_req[0]), 32'd1);
    wr(32'hC, 32'd0);
    chk("second_ack", 32'(interrupt_req[0]), 32'd0);

    // Software lines.
    wr(32'h100, 32'd3);
    chk("sw_set", 32'(interrupt_req[3:2]), 32'd3);
    wr(32'h104, 32'd1);
    chk("sw_clear", 32'(interrupt_req[3:2]), 32'd2);
    rd(32'h108); chk("sw_status", io_read_data, 32'd2);
    wr(32'h104, 32'd3);

    // LOAD=0 never fires; unmapped and read-only accesses.
    wr(32'h0, 32'd0);
    wr(32'h8, 32'd3);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (interrupt_req[0]) highs++;
    end
    chk("load0_no_event", 32'(highs), 32'd0);
    rd(32'h8); chk("load0_ctrl", io_read_data, 32'd3);
    rd(32'hF0); chk("unmapped_read", io_read_data, 32'd0);
    wr(32'h4, 32'd55);
    rd(32'h4); chk("count_write_ignored", io_read_data, 32'd0);

    // Reset while a periodic level timer and a SW line are active.
    wr(32'h0, 32'd6);
    wr(32'h8, 32'd3);
    wr(32'h100, 32'd1);
    for (int i = 0; i < 8; i++) idle();
    chk("pre_reset_active", 32'(interrupt_req[2:0]), 32'd5);
    do_reset();
    chk("reset_mid_irq", 32'(interrupt_req), 32'd0);
    rd(32'h4); chk("reset_mid_count", io_read_data, 32'd0);
    rd(32'h8); chk("reset_mid_ctrl", io_read_data, 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (interrupt_req != '0) highs++;
    end
    chk("no_events_after_reset", 32'(highs), 32'd0);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) idle();
      else if (r < 56) begin
        off = 32'h10 * $urandom_range(0, NT - 1) + 32'h4 * $urandom_range(0, 3);
        wr(off, off[3:2] == 2'd0 ? 32'($urandom_range(0, 25)) :
                off[3:2] == 2'd2 ? 32'($urandom_range(0, 7)) : $urandom);
      end else if (r < 66) wr($urandom_range(0, 1) ? 32'h100 : 32'h104, $urandom);
      else if (r < 90) begin
        case ($urandom_range(0, 2))
          0: off = 32'h10 * $urandom_range(0, NT - 1) + 32'h4 * $urandom_range(0, 3);
          1: off = 32'h100 + 32'h4 * $urandom_range(0, 3);
          default: off = 32'($urandom_range(0, 32'h110));
        endcase
        rd(off);
      end else if (r < 91) do_reset();
      else if (r < 95) wr(32'($urandom_range(0, 32'h120)), $urandom);
      else cyc_op(1'b0, $urandom_range(0, 1), 1'b0, BASE - 32'h4, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
